// File: rtl/rtc_time_keeper.sv
// hh:mm:ss real-time clock with a seconds prescaler, a BCD carry cascade and a periodic report strobe.
// Optional load range checking is enabled by defining RTC_LOAD_CHECK_EN.
module rtc_time_keeper #(
  parameter int clk_frec      = 50000000,
  parameter int report_period = 10
) (
  input  logic            clk,
  input  logic            arst,
  input  logic [5:0][7:0] time_reg,
  input  logic            new_time,
  output logic [5:0][7:0] cur_time,
  output logic            time_valid,
  output logic            sec_tick,
  output logic            send_h_t,
  output logic            load_err
);

  localparam int PW = (clk_frec > 1) ? $clog2(clk_frec) : 1;
  localparam int RW = $clog2(report_period + 1);
  localparam logic [PW-1:0] PRESC_TC  = PW'(clk_frec - 1);
  localparam logic [RW-1:0] REPORT_TC = RW'(report_period - 1);

  typedef enum logic {UNSYNCED, SYNCED} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   presc;
  logic [RW-1:0]   report_cnt;
  logic            tc;
  logic            accept;
  logic            c0, c1, c2, c3;
  logic            hours_bad;
  logic [5:0][7:0] inc_time;

  assign tc         = (presc == PRESC_TC);
  assign time_valid = (state == SYNCED);

`ifdef RTC_LOAD_CHECK_EN
  function automatic logic time_ok(input logic [5:0][7:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (t[i] > 8'd9) ok = 1'b0;
    if (t[5] > 8'd2 || t[3] > 8'd5 || t[1] > 8'd5) ok = 1'b0;
    if (t[5] == 8'd2 && t[4] > 8'd3) ok = 1'b0;
    return ok;
  endfunction

  logic load_ok;
  assign load_ok = time_ok(time_reg);
  assign accept  = new_time && load_ok;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) load_err <= 1'b0;
    else      load_err <= new_time && !load_ok;
  end
`else
  assign accept   = new_time;
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= UNSYNCED;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      UNSYNCED: if (accept) state_nxt = SYNCED;
      SYNCED:   state_nxt = SYNCED;
      default:  state_nxt = UNSYNCED;
    endcase
  end

  // Out-of-range hours are forced to 00 on any tick so a bad load heals.
  always_comb begin
    inc_time  = cur_time;
    hours_bad = (cur_time[5] > 8'd2) || (cur_time[4] > 8'd9) ||
                (cur_time[5] == 8'd2 && cur_time[4] > 8'd3);
    c0 = cur_time[0] >= 8'd9;
    c1 = c0 && (cur_time[1] >= 8'd5);
    c2 = c1 && (cur_time[2] >= 8'd9);
    c3 = c2 && (cur_time[3] >= 8'd5);
    inc_time[0] = c0 ? 8'd0 : cur_time[0] + 8'd1;
    if (c0) inc_time[1] = c1 ? 8'd0 : cur_time[1] + 8'd1;
    if (c1) inc_time[2] = c2 ? 8'd0 : cur_time[2] + 8'd1;
    if (c2) inc_time[3] = c3 ? 8'd0 : cur_time[3] + 8'd1;
    if (c3) begin
      if (cur_time[5] >= 8'd2 && cur_time[4] >= 8'd3) begin
        inc_time[5] = 8'd0;
        inc_time[4] = 8'd0;
      end else if (cur_time[4] >= 8'd9) begin
        inc_time[4] = 8'd0;
        inc_time[5] = cur_time[5] + 8'd1;
      end else begin
        inc_time[4] = cur_time[4] + 8'd1;
      end
    end
    if (hours_bad) begin
      inc_time[5] = 8'd0;
      inc_time[4] = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cur_time   <= '0;
      presc      <= '0;
      report_cnt <= '0;
      sec_tick   <= 1'b0;
      send_h_t   <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      send_h_t <= 1'b0;
      if (accept) begin
        cur_time   <= time_reg;
        presc      <= '0;
        report_cnt <= '0;
      end else begin
        presc <= tc ? '0 : presc + 1'b1;
        if (tc) begin
          cur_time <= inc_time;
          sec_tick <= 1'b1;
          if (state == SYNCED) begin
            if (report_cnt == REPORT_TC) begin
              report_cnt <= '0;
              send_h_t   <= 1'b1;
            end else begin
              report_cnt <= report_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Scoreboard bench for rtc_time_keeper: stimulus queues expected ticks,
// a monitor pops and compares them whenever sec_tick is seen.
module tb_rtc_time_keeper;

  localparam int F = 10;
  localparam int P = 3;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic            new_time = 1'b0;
  logic [5:0][7:0] time_reg = '0;
  logic [5:0][7:0] cur_time;
  logic            time_valid;
  logic            sec_tick;
  logic            send_h_t;
  logic            load_err;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int              c;
    logic [5:0][7:0] t;
    bit              s;
  } exp_t;

  exp_t q[$];
  exp_t e;

  rtc_time_keeper #(
    .clk_frec(F),
    .report_period(P)
  ) dut (
    .clk(clk),
    .arst(arst),
    .time_reg(time_reg),
    .new_time(new_time),
    .cur_time(cur_time),
    .time_valid(time_valid),
    .sec_tick(sec_tick),
    .send_h_t(send_h_t),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0][7:0] hms(input int h, input int m, input int s);
    return {8'(h / 10), 8'(h % 10), 8'(m / 10), 8'(m % 10), 8'(s / 10), 8'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [5:0][7:0] t, input bit s);
    exp_t x;
    x.c = c;
    x.t = t;
    x.s = s;
    q.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge after the load edge.
  task automatic do_load(input logic [5:0][7:0] t, output int le);
    time_reg = t;
    new_time = 1'b1;
    le = cyc + 1;
    @(posedge clk);
    #1 new_time = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain_timeout: %0d ticks still pending, expected 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      if (send_h_t) chk("send_with_tick", 64'(sec_tick), 64'd1);
      if (sec_tick) begin
        if (q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_tick: got tick at cycle %0d time %h, expected none",
                   cyc, cur_time);
        end else begin
          e = q.pop_front();
          chk("tick_cycle", 64'(e.c) == 64'(cyc) ? 64'd1 : 64'd0, 64'd1);
          chk("tick_time", 64'(cur_time), 64'(e.t));
          chk("tick_send", 64'(send_h_t), 64'(e.s));
        end
      end
    end
  end

  initial begin
    int c;
    int l;
    int l2;
    repeat (3) @(negedge clk);
    chk("rst_time", 64'(cur_time), 64'd0);
    chk("rst_valid", 64'(time_valid), 64'd0);
    chk("rst_tick", 64'(sec_tick), 64'd0);
    chk("rst_send", 64'(send_h_t), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);

    c = cyc;
    arst = 1'b0;
    push(c + 10, hms(0, 0, 1), 1'b0);
    drain();

    repeat (2) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    chk("async_rst_time", 64'(cur_time), 64'd0);
    chk("async_rst_valid", 64'(time_valid), 64'd0);
    chk("async_rst_tick", 64'(sec_tick), 64'd0);
    chk("async_rst_send", 64'(send_h_t), 64'd0);
    @(negedge clk);
    c = cyc;
    arst = 1'b0;
    for (int k = 1; k <= 3; k++) push(c + 10 * k, hms(0, 0, k), 1'b0);
    drain();
    chk("unsynced_valid", 64'(time_valid), 64'd0);

    do_load(hms(12, 0, 0), l);
    chk("load_time", 64'(cur_time), 64'(hms(12, 0, 0)));
    chk("load_valid", 64'(time_valid), 64'd1);
    chk("load_no_tick", 64'(sec_tick), 64'd0);
    for (int k = 1; k <= 9; k++) push(l + 10 * k, hms(12, 0, k), (k % 3) == 0);
    drain();

    do_load(hms(23, 59, 58), l);
    push(l + 10, hms(23, 59, 59), 1'b0);
    push(l + 20, hms(0, 0, 0), 1'b0);
    drain();

    do_load(hms(0, 0, 0), l);
    push(l + 10, hms(0, 0, 1), 1'b0);
    drain();
    while (cyc < l + 19) @(negedge clk);
    do_load(hms(8, 15, 30), l2);
    chk("collision_edge", 64'(l2), 64'(l + 20));
    chk("collision_time", 64'(cur_time), 64'(hms(8, 15, 30)));
    chk("collision_no_tick", 64'(sec_tick), 64'd0);
    push(l2 + 10, hms(8, 15, 31), 1'b0);
    drain();

    do_load(hms(9, 59, 59), l);
    push(l + 10, hms(10, 0, 0), 1'b0);
    drain();
    do_load(hms(19, 59, 59), l);
    push(l + 10, hms(20, 0, 0), 1'b0);
    drain();

`ifdef RTC_LOAD_CHECK_EN
    do_load(hms(25, 0, 0), l2);
    chk("reject_err", 64'(load_err), 64'd1);
    chk("reject_time", 64'(cur_time), 64'(hms(20, 0, 0)));
    chk("reject_valid", 64'(time_valid), 64'd1);
    @(negedge clk);
    chk("reject_err_width", 64'(load_err), 64'd0);
    push(l + 20, hms(20, 0, 1), 1'b0);
    drain();
`else
    do_load(hms(25, 0, 0), l);
    chk("bad_load_time", 64'(cur_time), 64'(hms(25, 0, 0)));
    chk("bad_load_err", 64'(load_err), 64'd0);
    push(l + 10, hms(0, 0, 1), 1'b0);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
